mem_ctrl: RTL and testbench

Memory controller and arbiter for the single byte-wide RAM port. It serves instruction-block fills for the ICache and byte, halfword and word loads and stores for the load/store buffer (LSB). Each access is serialised into byte transfers, little-endian. It sits between the ICache/LSB and the top-level RAM and IO interface. A misprediction flush from the RoB cancels speculative reads.

---
 rtl/mem_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter and byte serialiser for the single byte-wide RAM port.
// Serves ICache block fills and LSB byte/half/word loads and stores, one
// byte per cycle, little-endian. A RoB flush cancels in-flight reads.
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (freezes all state)
//   mem_din/mem_dout/mem_a/mem_wr  RAM port (read data valid the cycle
//                                  after the address is presented)
//   io_buffer_full                 UART output buffer full, gates IO stores
//   IC2MC_en/IC2MC_addr            ICache fill request
//   MC2IC_en/MC2IC_block           fill done pulse and block (word 0 low)
//   LSB2MC_en/_wr/_len/_addr/_data LSB request
//   MC2LSB_en/MC2LSB_data          LSB done pulse and zero-extended load data
//   RoB2MC_flush                   misprediction flush
module mem_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 1
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic [7:0]                     mem_din,
    output logic [7:0]                     mem_dout,
    output logic [ADDR_WIDTH-1:0]          mem_a,
    output logic                           mem_wr,
    input  logic                           io_buffer_full,
    input  logic                           IC2MC_en,
    input  logic [ADDR_WIDTH-1:0]          IC2MC_addr,
    output logic                           MC2IC_en,
    output logic [32*(1<<BLOCK_WIDTH)-1:0] MC2IC_block,
    input  logic                           LSB2MC_en,
    input  logic                           LSB2MC_wr,
    input  logic [1:0]                     LSB2MC_len,
    input  logic [ADDR_WIDTH-1:0]          LSB2MC_addr,
    input  logic [31:0]                    LSB2MC_data,
    output logic                           MC2LSB_en,
    output logic [31:0]                    MC2LSB_data,
    input  logic                           RoB2MC_flush
);

    localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;
    localparam int BLK_BITS   = 32 * BLOCK_SIZE;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IFETCH = 2'd1;
    localparam logic [1:0] S_LOAD   = 2'd2;
    localparam logic [1:0] S_STORE  = 2'd3;

    localparam logic [3:0] IC_LAST = 4'(4 * BLOCK_SIZE - 1);

    logic [1:0]            state;
    logic [3:0]            cnt;        // index of the byte in flight
    logic [3:0]            last;       // N-1 for the current transaction
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           sdata;
    logic                  is_io;
    logic [BLK_BITS-1:0]   cap;        // bytes captured so far, rest zero
    logic                  mem_wr_q;

    logic [3:0]            cnt_inc;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [BLK_BITS-1:0]   merged;
    logic [7:0]            byte_next;
    logic                  io_ok;
    logic                  lsb_req;
    logic                  ic_req;
    logic                  lsb_io;
    logic                  lsb_io_ok;
    logic [3:0]            lsb_last;
    logic [ADDR_WIDTH-1:0] ic_base;

    // rdy_in low must never leave a write strobe asserted on the RAM.
    assign mem_wr = mem_wr_q & rdy_in;

    always_comb begin
        cnt_inc   = cnt + 4'd1;
        addr_next = base + ADDR_WIDTH'(cnt_inc);
        merged    = cap | (BLK_BITS'(mem_din) << {cnt, 3'b000});
        byte_next = 8'(sdata >> {cnt_inc, 3'b000});
        io_ok     = !is_io || !io_buffer_full;
        // A requester whose done pulse is still high is not re-served.
        lsb_req   = LSB2MC_en && !MC2LSB_en && !RoB2MC_flush;
        ic_req    = IC2MC_en && !MC2IC_en && !RoB2MC_flush;
        lsb_io    = (LSB2MC_addr[17:16] == 2'b11);
        lsb_io_ok = !lsb_io || !io_buffer_full;
        ic_base   = IC2MC_addr & ~ADDR_WIDTH'(4 * BLOCK_SIZE - 1);
        lsb_last  = 4'd3;
        case (LSB2MC_len)
            2'd0:    lsb_last = 4'd0;
            2'd1:    lsb_last = 4'd1;
            default: lsb_last = 4'd3;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= S_IDLE;
            cnt         <= '0;
            last        <= '0;
            base        <= '0;
            sdata       <= '0;
            is_io       <= 1'b0;
            cap         <= '0;
            mem_a       <= '0;
            mem_dout    <= '0;
            mem_wr_q    <= 1'b0;
            MC2IC_en    <= 1'b0;
            MC2LSB_en   <= 1'b0;
            MC2IC_block <= '0;
            MC2LSB_data <= '0;
        end else if (rdy_in) begin
            MC2IC_en  <= 1'b0;
            MC2LSB_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    mem_a    <= '0;
                    mem_wr_q <= 1'b0;
                    // LSB wins: it belongs to older instructions.
                    if (lsb_req) begin
                        base  <= LSB2MC_addr;
                        mem_a <= LSB2MC_addr;
                        cnt   <= '0;
                        last  <= lsb_last;
                        sdata <= LSB2MC_data;
                        is_io <= LSB2MC_wr && lsb_io;
                        cap   <= '0;
                        if (LSB2MC_wr) begin
                            state    <= S_STORE;
                            mem_dout <= LSB2MC_data[7:0];
                            mem_wr_q <= lsb_io_ok;
                        end else begin
                            state <= S_LOAD;
                        end
                    end else if (ic_req) begin
                        base  <= ic_base;
                        mem_a <= ic_base;
                        cnt   <= '0;
                        last  <= IC_LAST;
                        is_io <= 1'b0;
                        cap   <= '0;
                        state <= S_IFETCH;
                    end
                end
                S_IFETCH, S_LOAD: begin
                    if (RoB2MC_flush) begin
                        state <= S_IDLE;
                        mem_a <= '0;
                        cnt   <= '0;
                        cap   <= '0;
                    end else if (cnt == last) begin
                        state <= S_IDLE;
                        mem_a <= '0;
                        cnt   <= '0;
                        if (state == S_IFETCH) begin
                            MC2IC_block <= merged;
                            MC2IC_en    <= 1'b1;
                        end else begin
                            MC2LSB_data <= merged[31:0];
                            MC2LSB_en   <= 1'b1;
                        end
                    end else begin
                        cap   <= merged;
                        cnt   <= cnt_inc;
                        mem_a <= addr_next;
                    end
                end
                S_STORE: begin
                    // mem_wr_q high means byte cnt was written this cycle;
                    // low means byte cnt is already set up and waiting on IO.
                    if (mem_wr_q) begin
                        if (cnt == last) begin
                            state     <= S_IDLE;
                            mem_a     <= '0;
                            mem_wr_q  <= 1'b0;
                            cnt       <= '0;
                            MC2LSB_en <= 1'b1;
                        end else begin
                            cnt      <= cnt_inc;
                            mem_a    <= addr_next;
                            mem_dout <= byte_next;
                            mem_wr_q <= io_ok;
                        end
                    end else begin
                        mem_wr_q <= io_ok;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a byte-array
// memory model. Expected load data, address sequences, latencies and store
// results are derived from the transaction rules, not from the RTL.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        IC2MC_en = 1'b0;
    logic [31:0] IC2MC_addr = '0;
    logic        MC2IC_en;
    logic [63:0] MC2IC_block;
    logic        LSB2MC_en = 1'b0;
    logic        LSB2MC_wr = 1'b0;
    logic [1:0]  LSB2MC_len = 2'd0;
    logic [31:0] LSB2MC_addr = '0;
    logic [31:0] LSB2MC_data = '0;
    logic        MC2LSB_en;
    logic [31:0] MC2LSB_data;
    logic        RoB2MC_flush = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ram     [logic [31:0]];   // what the DUT actually wrote
    logic [7:0] exp_mem [logic [31:0]];   // what memory should hold

    mem_ctrl #(.ADDR_WIDTH(32), .BLOCK_WIDTH(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .IC2MC_en(IC2MC_en), .IC2MC_addr(IC2MC_addr),
        .MC2IC_en(MC2IC_en), .MC2IC_block(MC2IC_block),
        .LSB2MC_en(LSB2MC_en), .LSB2MC_wr(LSB2MC_wr), .LSB2MC_len(LSB2MC_len),
        .LSB2MC_addr(LSB2MC_addr), .LSB2MC_data(LSB2MC_data),
        .MC2LSB_en(MC2LSB_en), .MC2LSB_data(MC2LSB_data),
        .RoB2MC_flush(RoB2MC_flush)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] rrd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] mrd(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : init_byte(a);
    endfunction

    // RAM: write on the edge, read data presented shortly after the edge
    // for the address now on mem_a.
    always @(posedge clk_in) begin
        if (mem_wr === 1'b1) ram[mem_a] = mem_dout;
        #1 mem_din = rrd(mem_a);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        ram[a] = v;
        exp_mem[a] = v;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk_in);
            chk("idle_mem_a", mem_a, 0);
            chk("idle_mem_wr", mem_wr, 0);
            chk("idle_lsb_en", MC2LSB_en, 0);
            chk("idle_ic_en", MC2IC_en, 0);
        end
    endtask

    // Called at a negedge. w = IO wait edges, flush_at = effective cycle
    // whose following edge sees a flush, stall_at = raw cycle starting a
    // 2-edge rdy_in stall (0 disables either).
    task automatic lsb_txn(input bit wr, input logic [1:0] len, input logic [31:0] addr,
                           input logic [31:0] data, input int w, input int flush_at,
                           input int stall_at, output logic [31:0] got);
        int n;
        int r;
        int e;
        int stalls;
        bit io;
        bit done;
        bit rdy_used;
        logic [31:0] expv;
        logic [31:0] ea;
        n = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        io = wr && (addr[17:16] == 2'b11);
        stalls = (stall_at > 0) ? 2 : 0;
        r = 0;
        e = 0;
        done = 1'b0;
        expv = '0;
        got = '0;
        for (int i = 0; i < n; i++) expv |= 32'(mrd(addr + 32'(i))) << (8 * i);
        LSB2MC_en = 1'b1;
        LSB2MC_wr = wr;
        LSB2MC_len = len;
        LSB2MC_addr = addr;
        LSB2MC_data = data;
        io_buffer_full = io ? (w > 0) : 1'($urandom_range(0, 1));
        rdy_in = 1'b1;
        rdy_used = 1'b1;
        while (!done && r < 64) begin
            @(negedge clk_in);
            r++;
            if (rdy_used) e++;
            chk("lsb_ic_quiet", MC2IC_en, 0);
            if (e <= w + n) begin
                ea = wr ? addr + 32'((e <= w) ? 0 : e - w - 1) : addr + 32'(e - 1);
                chk("lsb_mem_a", mem_a, ea);
                chk("lsb_mem_wr", mem_wr, (wr && e > w && rdy_in) ? 1 : 0);
                if (wr && e > w)
                    chk("lsb_mem_dout", mem_dout, 8'(data >> (8 * (e - w - 1))));
                chk("lsb_early_done", MC2LSB_en, 0);
            end else begin
                chk("lsb_done", MC2LSB_en, 1);
                chk("lsb_done_mem_a", mem_a, 0);
                chk("lsb_done_mem_wr", mem_wr, 0);
                chk("lsb_latency", r, n + 1 + w + stalls);
                if (!wr) chk("lsb_load_data", MC2LSB_data, expv);
                got = MC2LSB_data;
                done = 1'b1;
            end
            if (done) begin
                LSB2MC_en = 1'b0;
                RoB2MC_flush = 1'b0;
                rdy_in = 1'b1;
                io_buffer_full = 1'b0;
            end else begin
                io_buffer_full = io ? (e < w) : 1'($urandom_range(0, 1));
                RoB2MC_flush = (flush_at > 0 && e == flush_at);
                rdy_in = !(stall_at > 0 && r >= stall_at && r < stall_at + 2);
                rdy_used = rdy_in;
            end
        end
        if (!done) begin
            chk("lsb_timeout", 1, 0);
            LSB2MC_en = 1'b0;
            RoB2MC_flush = 1'b0;
            rdy_in = 1'b1;
        end
        if (wr) begin
            for (int i = 0; i < n; i++) begin
                exp_mem[addr + 32'(i)] = 8'(data >> (8 * i));
                chk("store_ram", rrd(addr + 32'(i)), mrd(addr + 32'(i)));
            end
        end
    endtask

    task automatic ic_txn(input logic [31:0] addr, output logic [63:0] got);
        logic [31:0] base;
        logic [63:0] expb;
        bit done;
        int r;
        base = addr & 32'hFFFF_FFF8;
        expb = '0;
        for (int i = 0; i < 8; i++) expb |= 64'(mrd(base + 32'(i))) << (8 * i);
        done = 1'b0;
        r = 0;
        got = '0;
        IC2MC_en = 1'b1;
        IC2MC_addr = addr;
        while (!done && r < 40) begin
            @(negedge clk_in);
            r++;
            chk("ic_lsb_quiet", MC2LSB_en, 0);
            if (r <= 8) begin
                chk("ic_mem_a", mem_a, base + 32'(r - 1));
                chk("ic_mem_wr", mem_wr, 0);
                chk("ic_early_done", MC2IC_en, 0);
            end else begin
                chk("ic_done", MC2IC_en, 1);
                chk("ic_block", MC2IC_block, expb);
                chk("ic_done_mem_a", mem_a, 0);
                got = MC2IC_block;
                done = 1'b1;
            end
            io_buffer_full = 1'($urandom_range(0, 1));
        end
        if (!done) chk("ic_timeout", 1, 0);
        IC2MC_en = 1'b0;
        io_buffer_full = 1'b0;
    endtask

    initial begin
        logic [31:0] g32;
        logic [63:0] g64;
        logic [31:0] ra;
        logic [31:0] rd;
        logic [1:0]  rl;

        repeat (2) @(negedge clk_in);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_dout", mem_dout, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_ic_en", MC2IC_en, 0);
        chk("rst_lsb_en", MC2LSB_en, 0);
        chk("rst_block", MC2IC_block, 0);
        chk("rst_lsb_data", MC2LSB_data, 0);
        rst_in = 1'b0;
        idle(1);

        // Block fill from an unaligned address.
        for (int i = 0; i < 8; i++) poke(32'h1000 + 32'(i), 8'(i));
        ic_txn(32'h1004, g64);
        chk("t1_block_lit", g64, 64'h0706050403020100);
        idle(1);

        // Simultaneous requests: LSB first, then the fill.
        poke(32'h2001, 8'hAA);
        poke(32'h2002, 8'hBB);
        poke(32'h2003, 8'hCC);
        poke(32'h2004, 8'hDD);
        IC2MC_en = 1'b1;
        IC2MC_addr = 32'h1004;
        lsb_txn(1'b0, 2'd2, 32'h2001, '0, 0, 0, 0, g32);
        chk("t2_lsb_word", g32, 32'hDDCCBBAA);
        ic_txn(32'h1004, g64);
        chk("t2_block_lit", g64, 64'h0706050403020100);
        idle(1);

        // Half store crossing 0x1000.
        lsb_txn(1'b1, 2'd1, 32'h0000_0FFF, 32'h1234_BEEF, 0, 0, 0, g32);
        chk("t3_byte_ef", rrd(32'h0FFF), 8'hEF);
        chk("t3_byte_be", rrd(32'h1000), 8'hBE);
        chk("t3_untouched", rrd(32'h1001), 8'h01);
        idle(2);

        // IO store held off by a full UART buffer for 3 edges.
        lsb_txn(1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041, 3, 0, 0, g32);
        chk("t4_io_byte", rrd(32'h0003_0000), 8'h41);
        idle(1);

        // Flush during a fill at cnt = 3.
        IC2MC_en = 1'b1;
        IC2MC_addr = 32'h1004;
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk_in);
            chk("t5_fill_mem_a", mem_a, 32'h1000 + 32'(r - 1));
        end
        RoB2MC_flush = 1'b1;
        @(negedge clk_in);
        chk("t5_flush_mem_a", mem_a, 0);
        chk("t5_flush_no_done", MC2IC_en, 0);
        RoB2MC_flush = 1'b0;
        IC2MC_en = 1'b0;
        idle(10);

        // Flush during a word store has no effect.
        lsb_txn(1'b1, 2'd2, 32'h0000_0500, 32'hCAFE_F00D, 0, 2, 0, g32);
        chk("t5_store_b0", rrd(32'h0500), 8'h0D);
        chk("t5_store_b3", rrd(32'h0503), 8'hCA);
        idle(1);

        // A flush blocks acceptance in IDLE.
        LSB2MC_en = 1'b1;
        LSB2MC_wr = 1'b0;
        LSB2MC_len = 2'd0;
        LSB2MC_addr = 32'h2001;
        RoB2MC_flush = 1'b1;
        repeat (2) begin
            @(negedge clk_in);
            chk("flush_no_grant_a", mem_a, 0);
            chk("flush_no_grant_en", MC2LSB_en, 0);
        end
        RoB2MC_flush = 1'b0;
        lsb_txn(1'b0, 2'd0, 32'h2001, '0, 0, 0, 0, g32);
        chk("flush_then_byte", g32, 32'h0000_00AA);
        idle(1);

        // Address wrap, len 3 treated as word.
        poke(32'hFFFF_FFFE, 8'h11);
        poke(32'hFFFF_FFFF, 8'h22);
        poke(32'h0000_0000, 8'h33);
        poke(32'h0000_0001, 8'h44);
        lsb_txn(1'b0, 2'd3, 32'hFFFF_FFFE, '0, 0, 0, 0, g32);
        chk("wrap_load", g32, 32'h4433_2211);
        idle(1);
        lsb_txn(1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_9988, 0, 0, 0, g32);
        chk("wrap_store_hi", rrd(32'hFFFF_FFFF), 8'h88);
        chk("wrap_store_lo", rrd(32'h0000_0000), 8'h99);
        idle(1);

        // rdy_in low for 2 cycles mid-load.
        lsb_txn(1'b0, 2'd2, 32'h2001, '0, 0, 0, 2, g32);
        chk("stall_load", g32, 32'hDDCCBBAA);
        idle(1);

        // Asynchronous reset mid-load.
        LSB2MC_en = 1'b1;
        LSB2MC_wr = 1'b0;
        LSB2MC_len = 2'd2;
        LSB2MC_addr = 32'h2001;
        repeat (3) @(negedge clk_in);
        #1 rst_in = 1'b1;
        #1;
        chk("arst_mem_a", mem_a, 0);
        chk("arst_mem_dout", mem_dout, 0);
        chk("arst_mem_wr", mem_wr, 0);
        chk("arst_lsb_data", MC2LSB_data, 0);
        chk("arst_block", MC2IC_block, 0);
        chk("arst_lsb_en", MC2LSB_en, 0);
        @(negedge clk_in);
        LSB2MC_en = 1'b0;
        rst_in = 1'b0;
        idle(3);

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else ra = 32'($urandom_range(0, 32'h0000_FFFF));
            rd = $urandom;
            rl = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       ic_txn(ra, g64);
                1:       lsb_txn(1'b0, rl, ra, rd, 0, 0, 0, g32);
                default: lsb_txn(1'b1, rl, ra, rd, 0, 0, 0, g32);
            endcase
            idle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
